// File: rtl/evp_pkg.sv
// Shared definitions for the EVP (evaluate polynomial) engine and its STP sibling.
package evp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_N,
        ST_CHK,
        ST_MAC,
        ST_ERROR,
        ST_END
    } evp_state_t;

    localparam int MAX_N      = 10;
    localparam int VEC_STRIDE = 11;

    localparam logic [31:0] STATUS_OK   = 32'd0;
    localparam logic [31:0] STATUS_ERR  = 32'd2;
    localparam logic [31:0] STATUS_NONE = 32'hFFFF_FFFF;

    // Ceiling log2, usable in constant expressions.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/evp_horner_mac.sv
// One Horner step: next_acc = acc * sext(x) + sext(c), wrapping modulo 2^32.
module evp_horner_mac (
    input  logic [31:0] i_acc,
    input  logic [15:0] i_x,
    input  logic [15:0] i_c,
    output logic [31:0] o_next_acc
);

    logic [31:0] w_x_ext;
    logic [31:0] w_c_ext;
    logic [31:0] w_prod;

    assign w_x_ext = {{16{i_x[15]}}, i_x};
    assign w_c_ext = {{16{i_c[15]}}, i_c};
    // Low 32 bits of a product are the same for signed and unsigned operands.
    assign w_prod     = i_acc * w_x_ext;
    assign o_next_acc = w_prod + w_c_ext;

endmodule

// File: rtl/evp_fsm.sv
// EVP instruction engine: reads N and coefficients for vector A, evaluates at x by Horner.
//  state | meaning
//  IDLE  | waiting for start_evp
//  RD_N  | N RAM read issued for vector A
//  CHK   | N returned; range check, first coefficient read issued
//  MAC   | one Horner step per cycle, next coefficient read issued
//  ERROR | N out of range, error status posted
//  END   | done_evp pulse
module evp_fsm
    import evp_pkg::*;
#(
    parameter int buffer_size = 1024,
    localparam int ADDR_W = log2(buffer_size)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_evp,
    input  logic [2:0]        A,
    input  logic [15:0]       x,
    input  logic [4:0]        rd_data_N,
    input  logic [15:0]       rd_data_S,
    output logic              en_rd_N,
    output logic [ADDR_W-1:0] rd_addr_N,
    output logic              en_rd_S,
    output logic [ADDR_W-1:0] rd_addr_S,
    output logic              done_evp,
    output logic [31:0]       result,
    output logic [31:0]       status
);

    evp_state_t  r_state;
    evp_state_t  w_state_nx;
    logic [2:0]  r_a;
    logic [15:0] r_x;
    logic [31:0] r_acc;
    logic [3:0]  r_k;
    logic [31:0] r_result;
    logic [31:0] r_status;

    logic [31:0] w_next_acc;
    logic [6:0]  w_base;
    logic [3:0]  w_k_dec;
    logic [6:0]  w_addr_s;
    logic        w_n_bad;

    evp_horner_mac u_mac (
        .i_acc      (r_acc),
        .i_x        (r_x),
        .i_c        (rd_data_S),
        .o_next_acc (w_next_acc)
    );

    assign w_base  = {4'd0, r_a} * 7'(VEC_STRIDE);
    assign w_k_dec = r_k - 4'd1;
    assign w_n_bad = rd_data_N > 5'(MAX_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_x      <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_result <= '0;
            r_status <= STATUS_NONE;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                ST_IDLE: begin
                    if (start_evp) begin
                        r_a      <= A;
                        r_x      <= x;
                        r_acc    <= '0;
                        r_status <= STATUS_NONE;
                    end
                end
                ST_CHK: begin
                    if (!w_n_bad) r_k <= rd_data_N[3:0];
                end
                ST_MAC: begin
                    r_acc <= w_next_acc;
                    if (r_k == 4'd0) begin
                        r_result <= w_next_acc;
                        r_status <= STATUS_OK;
                    end else begin
                        r_k <= w_k_dec;
                    end
                end
                ST_ERROR: begin
                    r_result <= '0;
                    r_status <= STATUS_ERR;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nx = r_state;
        en_rd_N    = 1'b0;
        en_rd_S    = 1'b0;
        rd_addr_N  = '0;
        w_addr_s   = '0;
        done_evp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_evp) w_state_nx = ST_RD_N;
            end
            ST_RD_N: begin
                en_rd_N    = 1'b1;
                rd_addr_N  = ADDR_W'(r_a);
                w_state_nx = ST_CHK;
            end
            ST_CHK: begin
                if (w_n_bad) begin
                    w_state_nx = ST_ERROR;
                end else begin
                    en_rd_S    = 1'b1;
                    w_addr_s   = w_base + {2'd0, rd_data_N};
                    w_state_nx = ST_MAC;
                end
            end
            ST_MAC: begin
                if (r_k == 4'd0) begin
                    w_state_nx = ST_END;
                end else begin
                    en_rd_S  = 1'b1;
                    w_addr_s = w_base + {3'd0, w_k_dec};
                end
            end
            ST_ERROR: w_state_nx = ST_END;
            ST_END: begin
                done_evp   = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign rd_addr_S = ADDR_W'(w_addr_s);
    assign result    = r_result;
    assign status    = r_status;

endmodule

// File: tb/tb_evp_fsm.sv
// Directed bench for evp_fsm with behavioural N/S RAMs and hand-computed results.
module tb_evp_fsm;

    logic        clk;
    logic        rst;
    logic        start_evp;
    logic [2:0]  A;
    logic [15:0] x;
    logic [4:0]  rd_data_N;
    logic [15:0] rd_data_S;
    logic        en_rd_N;
    logic [9:0]  rd_addr_N;
    logic        en_rd_S;
    logic [9:0]  rd_addr_S;
    logic        done_evp;
    logic [31:0] result;
    logic [31:0] status;

    logic [4:0]  nram [0:1023];
    logic [15:0] sram [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    evp_fsm #(.buffer_size(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_evp (start_evp),
        .A         (A),
        .x         (x),
        .rd_data_N (rd_data_N),
        .rd_data_S (rd_data_S),
        .en_rd_N   (en_rd_N),
        .rd_addr_N (rd_addr_N),
        .en_rd_S   (en_rd_S),
        .rd_addr_S (rd_addr_S),
        .done_evp  (done_evp),
        .result    (result),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en_rd_N) rd_data_N <= nram[rd_addr_N];
        if (en_rd_S) rd_data_S <= sram[rd_addr_S];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One EVP run; optionally pulses start_evp again at cycle inj_cyc.
    task automatic run_evp(input string name, input logic [2:0] a, input logic [15:0] xv,
                           input int n, input int exp_sreads, input int exp_lat,
                           input logic [31:0] exp_res, input logic [31:0] exp_stat,
                           input int inj_cyc);
        int  edges, s_reads, n_reads, both;
        bit  seen_done;
        logic [31:0] exp_addr;
        @(posedge clk); #1;
        A = a; x = xv; start_evp = 1'b1;
        @(posedge clk); #1;
        start_evp = 1'b0; A = ~a; x = ~xv;
        edges = 1; s_reads = 0; n_reads = 0; both = 0; seen_done = 0;
        check({name, "_busy_status"}, status, 32'hFFFF_FFFF);
        while (!seen_done && edges < 40) begin
            if (done_evp) begin
                seen_done = 1;
            end else begin
                if (en_rd_N) begin
                    n_reads++;
                    check({name, "_addr_N"}, 32'(rd_addr_N), 32'(a));
                end
                if (en_rd_S) begin
                    exp_addr = 32'(int'(a) * 11 + n - s_reads);
                    check({name, "_addr_S"}, 32'(rd_addr_S), exp_addr);
                    s_reads++;
                end
                if (en_rd_N && en_rd_S) both++;
                start_evp = (edges == inj_cyc);
                @(posedge clk); #1;
                edges++;
            end
        end
        start_evp = 1'b0;
        check({name, "_done_seen"}, 32'(seen_done), 32'd1);
        check({name, "_latency"}, 32'(edges), 32'(exp_lat));
        check({name, "_n_reads"}, 32'(n_reads), 32'd1);
        check({name, "_s_reads"}, 32'(s_reads), 32'(exp_sreads));
        check({name, "_both_en"}, 32'(both), 32'd0);
        check({name, "_result"}, result, exp_res);
        check({name, "_status"}, status, exp_stat);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(done_evp), 32'd0);
        check({name, "_result_hold"}, result, exp_res);
        check({name, "_status_hold"}, status, exp_stat);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 1024; i++) begin
            nram[i] = '0;
            sram[i] = '0;
        end
        rd_data_N = '0; rd_data_S = '0;
        nram[2] = 5'd3;
        sram[22] = 16'd1; sram[23] = 16'd2; sram[24] = 16'd3; sram[25] = 16'd4;
        nram[7] = 5'd0;  sram[77] = 16'hFFFB;
        nram[1] = 5'd12;
        nram[4] = 5'd11;
        nram[0] = 5'd3;
        for (int i = 0; i < 4; i++) sram[i] = 16'd1;
        nram[3] = 5'd10;
        for (int i = 33; i <= 43; i++) sram[i] = 16'd1;

        rst = 1'b1; start_evp = 1'b0; A = '0; x = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_done", 32'(done_evp), 32'd0);
        check("rst_en_N", 32'(en_rd_N), 32'd0);
        check("rst_en_S", 32'(en_rd_S), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_status", status, 32'hFFFF_FFFF);

        run_evp("n3",      3'd2, 16'd2,     3,  4, 7,  32'd49,        32'd0, -1);
        run_evp("n0_neg",  3'd7, 16'd100,   0,  1, 4,  32'hFFFF_FFFB, 32'd0, -1);
        run_evp("err12",   3'd1, 16'd5,     0,  0, 4,  32'd0,         32'd2, -1);
        run_evp("n3_again",3'd2, 16'd2,     3,  4, 7,  32'd49,        32'd0, -1);
        run_evp("err11",   3'd4, 16'd5,     0,  0, 4,  32'd0,         32'd2, -1);
        run_evp("ovf",     3'd0, 16'h1000,  3,  4, 7,  32'h0100_1001, 32'd0, -1);
        run_evp("sign",    3'd3, 16'hFFFF,  10, 11, 14, 32'd1,        32'd0, -1);
        run_evp("inj",     3'd2, 16'd2,     3,  4, 7,  32'd49,        32'd0, 4);

        // Reset while in MAC.
        @(posedge clk); #1;
        A = 3'd2; x = 16'd2; start_evp = 1'b1;
        @(posedge clk); #1;
        start_evp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mac_rd_active", 32'(en_rd_S), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_en_S", 32'(en_rd_S), 32'd0);
        check("mrst_done", 32'(done_evp), 32'd0);
        check("mrst_status", status, 32'hFFFF_FFFF);
        check("mrst_result", result, 32'd0);
        bad = 0;
        repeat (10) begin
            if (en_rd_S || en_rd_N || done_evp) bad++;
            @(posedge clk); #1;
        end
        check("mrst_quiet", 32'(bad), 32'd0);

        // Reset mid-idle after a good result.
        run_evp("pre_idle_rst", 3'd7, 16'd1, 0, 1, 4, 32'hFFFF_FFFB, 32'd0, -1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("irst_result", result, 32'd0);
        check("irst_status", status, 32'hFFFF_FFFF);
        check("irst_done", 32'(done_evp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
